// File: rtl/pipe_regalu.sv
// Three-stage EX/MEM/WB execute datapath: register file, forwarding ALU, data memory,
// with a one-cycle load-use stall exposed through a valid/ready issue handshake.
module pipe_regalu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 5,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int A0_INDEX       = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic                     RegWrite,
    input  logic                     ALUsrc,
    input  logic                     ResultSrc,
    input  logic                     MemWrite,
    input  logic [2:0]               ALUCtrl,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    output logic                     eq,
    output logic                     retire_o,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int unsigned NREGS = 2 ** ADDRESS_WIDTH;
    localparam int unsigned MDEPTH = 2 ** MEM_ADDR_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(A0_INDEX);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic [DATA_WIDTH-1:0] dmem [MDEPTH];

    // EX -> MEM pipeline register
    logic                     m_valid, m_regwrite, m_resultsrc, m_memwrite;
    logic [ADDRESS_WIDTH-1:0] m_rd;
    logic [DATA_WIDTH-1:0]    m_alu, m_store;

    // MEM -> WB pipeline register
    logic                     w_valid, w_regwrite;
    logic [ADDRESS_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0]    w_data;

    logic [DATA_WIDTH-1:0]     rs1_val, rs2_val, op1, op2, alu_res;
    logic [MEM_ADDR_WIDTH-1:0] m_addr;
    logic                      load_use, transfer;

    function automatic logic [DATA_WIDTH-1:0] fwd(input logic [ADDRESS_WIDTH-1:0] idx);
        if (idx == '0)
            return '0;
        else if (m_valid && m_regwrite && !m_resultsrc && m_rd == idx)
            return m_alu;
        else if (w_valid && w_regwrite && w_rd == idx)
            return w_data;
        else
            return regs[idx];
    endfunction

    always_comb begin
        rs1_val = fwd(rs1);
        rs2_val = fwd(rs2);
        op1     = rs1_val;
        op2     = ALUsrc ? ImmOp : rs2_val;
    end

    always_comb begin
        alu_res = '0;
        case (alu_op_e'(ALUCtrl))
            ALU_ADD: alu_res = op1 + op2;
            ALU_SUB: alu_res = op1 - op2;
            ALU_AND: alu_res = op1 & op2;
            ALU_OR:  alu_res = op1 | op2;
            ALU_XOR: alu_res = op1 ^ op2;
            ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLL: alu_res = op1 << op2[4:0];
            ALU_SRL: alu_res = op1 >> op2[4:0];
            default: alu_res = '0;
        endcase
    end

    // A load still in MEM cannot be forwarded; rs2 only matters when it is actually consumed.
    always_comb begin
        load_use = m_valid && m_regwrite && m_resultsrc && (m_rd != '0) &&
                   ((m_rd == rs1) || ((m_rd == rs2) && (!ALUsrc || MemWrite)));
        ready_o  = !rst && !load_use;
        transfer = valid_i && ready_o;
    end

    assign m_addr   = m_alu[MEM_ADDR_WIDTH+1:2];
    assign retire_o = w_valid;
    assign a0       = regs[A0_IDX];

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_regwrite  <= 1'b0;
            m_resultsrc <= 1'b0;
            m_memwrite  <= 1'b0;
            w_valid     <= 1'b0;
            w_regwrite  <= 1'b0;
            eq          <= 1'b0;
            regs        <= '{default: '0};
        end else begin
            m_valid <= transfer;
            if (transfer) begin
                m_alu       <= alu_res;
                m_store     <= rs2_val;
                m_rd        <= rd;
                m_regwrite  <= RegWrite;
                m_resultsrc <= ResultSrc;
                m_memwrite  <= MemWrite;
                eq          <= (op1 == op2);
            end
            w_valid <= m_valid;
            if (m_valid) begin
                w_rd       <= m_rd;
                w_regwrite <= m_regwrite;
                w_data     <= m_resultsrc ? dmem[m_addr] : m_alu;
            end
            if (w_valid && w_regwrite && w_rd != '0)
                regs[w_rd] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && m_valid && m_memwrite)
            dmem[m_addr] <= m_store;
    end

endmodule

// File: tb/tb_pipe_regalu.sv
// Directed table-driven bench for pipe_regalu: one row per issue cycle, register
// contents observed through eq (compare against ImmOp) and a0.
module tb_pipe_regalu;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, SLT = 3'b101, SLL = 3'b110, SRL = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o;
    logic [4:0]  rs1, rs2, rd;
    logic        RegWrite, ALUsrc, ResultSrc, MemWrite;
    logic [2:0]  ALUCtrl;
    logic [31:0] ImmOp;
    logic        eq, retire_o;
    logic [31:0] a0;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, src, rsrc, mw;
        logic [2:0]  ctl;
        logic [31:0] imm;
        logic        rdy, eqv, ret, ca0;
        logic [31:0] a0v;
    } vec_t;

    vec_t tbl[$];

    pipe_regalu #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(5),
        .MEM_ADDR_WIDTH(8),
        .A0_INDEX(10)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
        .ResultSrc(ResultSrc), .MemWrite(MemWrite), .ALUCtrl(ALUCtrl), .ImmOp(ImmOp),
        .eq(eq), .retire_o(retire_o), .a0(a0)
    );

    always #5 clk = ~clk;

    task automatic add(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic rw, input logic src, input logic rsrc, input logic mw,
                       input logic [2:0] ctl, input logic [31:0] imm,
                       input logic rdy, input logic eqv, input logic ret,
                       input logic ca0, input logic [31:0] a0v);
        vec_t r;
        r.v = v; r.rs1 = r1; r.rs2 = r2; r.rd = d; r.rw = rw; r.src = src; r.rsrc = rsrc;
        r.mw = mw; r.ctl = ctl; r.imm = imm; r.rdy = rdy; r.eqv = eqv; r.ret = ret;
        r.ca0 = ca0; r.a0v = a0v;
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        valid_i = r.v; rs1 = r.rs1; rs2 = r.rs2; rd = r.rd; RegWrite = r.rw; ALUsrc = r.src;
        ResultSrc = r.rsrc; MemWrite = r.mw; ALUCtrl = r.ctl; ImmOp = r.imm;
    endtask

    task automatic idle();
        valid_i = 1'b0; rs1 = '0; rs2 = '0; rd = '0; RegWrite = 1'b0; ALUsrc = 1'b0;
        ResultSrc = 1'b0; MemWrite = 1'b0; ALUCtrl = ADD; ImmOp = '0;
    endtask

    initial begin
        vec_t r;
        // v rs1 rs2 rd  rw src rsrc mw ctl imm           rdy eq ret ca0 a0
        add(1, 0, 0, 1,   1, 1, 0, 0, ADD, 32'd5,          1, 0, 0, 0, 0);           // addi x1,x0,5
        add(1, 1, 1, 2,   1, 0, 0, 0, ADD, 32'd0,          1, 1, 1, 0, 0);           // add x2,x1,x1
        add(1, 2, 1, 3,   1, 0, 0, 0, SUB, 32'd0,          1, 0, 1, 0, 0);           // sub x3,x2,x1
        add(1, 3, 0, 0,   0, 1, 0, 0, ADD, 32'd5,          1, 1, 1, 0, 0);           // x3 == 5
        add(1, 2, 0, 0,   0, 1, 0, 0, ADD, 32'd10,         1, 1, 1, 0, 0);           // x2 == 10
        add(1, 0, 0, 11,  1, 1, 0, 0, ADD, 32'hDEADBEEF,   1, 0, 1, 0, 0);           // x11 = DEADBEEF
        add(1, 0, 11, 0,  0, 1, 0, 1, ADD, 32'd8,          1, 0, 1, 0, 0);           // sw x11,8(x0)
        add(1, 0, 0, 4,   1, 1, 1, 0, ADD, 32'd8,          1, 0, 1, 0, 0);           // lw x4,8(x0)
        add(1, 4, 0, 5,   1, 0, 0, 0, ADD, 32'd0,          0, 0, 1, 0, 0);           // add x5,x4,x0 stalls
        add(1, 4, 0, 5,   1, 0, 0, 0, ADD, 32'd0,          1, 0, 0, 0, 0);           // accepted
        add(1, 5, 0, 0,   0, 1, 0, 0, ADD, 32'hDEADBEEF,   1, 1, 1, 0, 0);           // x5 == DEADBEEF
        add(1, 0, 0, 0,   1, 1, 0, 0, ADD, 32'd7,          1, 0, 1, 0, 0);           // addi x0,x0,7
        add(1, 0, 0, 6,   1, 0, 0, 0, ADD, 32'd0,          1, 1, 1, 0, 0);           // add x6,x0,x0
        add(1, 0, 0, 10,  1, 1, 0, 0, ADD, 32'hFFFFFFFF,   1, 0, 1, 1, 0);           // addi x10,x0,-1
        add(1, 10, 0, 7,  1, 0, 0, 0, SLT, 32'd0,          1, 0, 1, 1, 0);           // slt x7,x10,x0
        add(1, 10, 0, 8,  1, 1, 0, 0, SRL, 32'd28,         1, 0, 1, 0, 0);           // srl x8,x10,28
        add(1, 7, 0, 0,   0, 1, 0, 0, ADD, 32'd1,          1, 1, 1, 1, 32'hFFFFFFFF); // x7 == 1
        add(1, 8, 0, 0,   0, 1, 0, 0, ADD, 32'hF,          1, 1, 1, 0, 0);           // x8 == F
        add(1, 0, 0, 12,  1, 1, 0, 0, ADD, 32'd3,          1, 0, 1, 0, 0);           // x12 = 3
        add(1, 12, 0, 0,  0, 1, 0, 0, ADD, 32'd3,          1, 1, 1, 0, 0);           // 3 vs 3
        add(1, 12, 0, 0,  0, 1, 0, 0, ADD, 32'd4,          1, 0, 1, 0, 0);           // 3 vs 4
        add(0, 12, 0, 0,  0, 1, 0, 0, ADD, 32'd3,          1, 0, 1, 0, 0);           // no transfer: eq holds
        add(0, 0, 0, 0,   0, 0, 0, 0, ADD, 32'd0,          1, 0, 0, 0, 0);
        add(1, 2, 11, 13, 1, 0, 0, 0, AND_, 32'd0,         1, 0, 0, 0, 0);           // and x13,x2,x11
        add(1, 13, 0, 0,  0, 1, 0, 0, ADD, 32'd10,         1, 1, 1, 0, 0);
        add(1, 1, 2, 14,  1, 0, 0, 0, OR_, 32'd0,          1, 0, 1, 0, 0);           // or x14,x1,x2
        add(1, 14, 0, 0,  0, 1, 0, 0, ADD, 32'd15,         1, 1, 1, 0, 0);
        add(1, 1, 11, 15, 1, 0, 0, 0, XOR_, 32'd0,         1, 0, 1, 0, 0);           // xor x15,x1,x11
        add(1, 15, 0, 0,  0, 1, 0, 0, ADD, 32'hDEADBEEA,   1, 1, 1, 0, 0);
        add(1, 1, 0, 16,  1, 1, 0, 0, SLL, 32'd36,         1, 0, 1, 0, 0);           // sll by 36 -> by 4
        add(1, 16, 0, 0,  0, 1, 0, 0, ADD, 32'h50,         1, 1, 1, 0, 0);
        add(1, 10, 0, 17, 1, 1, 0, 0, ADD, 32'd2,          1, 0, 1, 0, 0);           // -1 + 2 wraps
        add(1, 17, 0, 0,  0, 1, 0, 0, ADD, 32'd1,          1, 1, 1, 0, 0);
        add(1, 1, 2, 18,  1, 0, 0, 0, SLT, 32'd0,          1, 0, 1, 0, 0);           // slt 5 < 10
        add(1, 18, 0, 0,  0, 1, 0, 0, ADD, 32'd1,          1, 1, 1, 0, 0);
        add(1, 0, 1, 0,   0, 1, 0, 1, ADD, 32'd1034,       1, 0, 1, 0, 0);           // sw x1 -> wraps to word 2
        add(1, 0, 0, 19,  1, 1, 1, 0, ADD, 32'd8,          1, 0, 1, 0, 0);           // lw x19,8(x0)
        add(1, 1, 19, 20, 1, 0, 0, 0, ADD, 32'd0,          0, 0, 1, 0, 0);           // rs2 load-use stall
        add(1, 1, 19, 20, 1, 0, 0, 0, ADD, 32'd0,          1, 1, 0, 0, 0);
        add(1, 0, 0, 21,  1, 1, 1, 0, ADD, 32'd8,          1, 0, 1, 0, 0);           // lw x21
        add(1, 0, 21, 22, 1, 1, 0, 0, ADD, 32'd9,          1, 0, 1, 0, 0);           // rs2 unused: no stall
        add(1, 20, 0, 0,  0, 1, 0, 0, ADD, 32'd10,         1, 1, 1, 0, 0);           // x20 == 10
        add(1, 0, 0, 23,  1, 1, 1, 0, ADD, 32'd8,          1, 0, 1, 0, 0);           // lw x23
        add(1, 0, 23, 0,  0, 1, 0, 1, ADD, 32'd16,         0, 0, 1, 0, 0);           // store of loaded reg stalls
        add(1, 0, 23, 0,  0, 1, 0, 1, ADD, 32'd16,         1, 0, 0, 0, 0);
        add(1, 0, 0, 24,  1, 1, 1, 0, ADD, 32'd16,         1, 0, 1, 0, 0);           // lw x24,16(x0)
        add(1, 1, 24, 0,  0, 0, 0, 0, ADD, 32'd0,          0, 0, 1, 0, 0);
        add(1, 1, 24, 0,  0, 0, 0, 0, ADD, 32'd0,          1, 1, 0, 0, 0);

        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_in_reset", -1, 32'(ready_o), 32'd0);
        @(posedge clk); #1;
        check("eq_after_reset", -1, 32'(eq), 32'd0);
        check("retire_after_reset", -1, 32'(retire_o), 32'd0);
        check("a0_after_reset", -1, a0, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            drive(r);
            @(negedge clk);
            check("ready", i, 32'(ready_o), 32'(r.rdy));
            @(posedge clk); #1;
            check("eq", i, 32'(eq), 32'(r.eqv));
            check("retire", i, 32'(retire_o), 32'(r.ret));
            if (r.ca0) check("a0", i, a0, r.a0v);
        end

        // addi x9,x0,1 accepted, then reset before it can write back
        r = tbl[0];
        r.rd = 5'd9; r.imm = 32'd1;
        drive(r);
        @(negedge clk);
        check("rst_seq_ready_issue", 100, 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        idle();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_seq_ready_low", 101 + k, 32'(ready_o), 32'd0);
            @(posedge clk); #1;
            check("rst_seq_retire", 101 + k, 32'(retire_o), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_seq_ready_back", 103, 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        check("rst_seq_retire_idle", 103, 32'(retire_o), 32'd0);
        check("rst_seq_a0", 103, a0, 32'd0);
        check("rst_seq_eq", 103, 32'(eq), 32'd0);

        r = tbl[3];
        r.rs1 = 5'd9; r.imm = 32'd1;      // x9 must not have been written
        drive(r);
        @(posedge clk); #1;
        check("rst_seq_x9_not_1", 104, 32'(eq), 32'd0);
        check("rst_seq_retire_late", 104, 32'(retire_o), 32'd0);
        r.rs1 = 5'd1; r.imm = 32'd0;      // x1 cleared by reset
        drive(r);
        @(posedge clk); #1;
        check("rst_seq_x1_zero", 105, 32'(eq), 32'd1);
        idle();
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
